// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH bits over
// WIDTH clock cycles, with a start/busy/done handshake and a registered product.
module multiplicador_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   saida
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;

  // The upper half of acc is the running partial product, the lower half holds
  // the not-yet-consumed multiplier bits; the adder carry lands in the MSB.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{acc[0]}}};
    acc_next = {sum, acc[WIDTH-1:1]};
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      saida <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= A;
            acc   <= {{WIDTH{1'b0}}, B};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            saida <= acc_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here; it is next sampled in IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq at WIDTH=4 and WIDTH=8; expected
// products are queued when an operation is launched and compared on each done.
module tb_multiplicador_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] saida4;

  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] saida8;

  multiplicador_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .saida(saida4)
  );

  multiplicador_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .saida(saida8)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] q4[$];
  logic [63:0] q8[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done4 === 1'b1) begin
      check("busy_done_excl4", busy4, 1'b0);
      check("pending4", q4.size() != 0, 1'b1);
      if (q4.size() != 0) check("saida4", saida4, q4.pop_front());
    end
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      check("busy_done_excl8", busy8, 1'b0);
      check("pending8", q8.size() != 0, 1'b1);
      if (q8.size() != 0) check("saida8", saida8, q8.pop_front());
    end
  end

  function automatic logic get_done(input bit wide);
    return wide ? done8 : done4;
  endfunction

  function automatic logic get_busy(input bit wide);
    return wide ? busy8 : busy4;
  endfunction

  // One start pulse; measures accept-to-done latency and busy duration.
  task automatic run_op(input bit wide, input int a, input int b);
    int w;
    int lat;
    int busy_cnt;
    w = wide ? 8 : 4;
    @(negedge clk);
    if (wide) begin
      start8 = 1'b1; a8 = 8'(a); b8 = 8'(b); q8.push_back(64'(a * b));
    end else begin
      start4 = 1'b1; a4 = 4'(a); b4 = 4'(b); q4.push_back(64'(a * b));
    end
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    a4 = ~a4; b4 = ~b4; a8 = ~a8; b8 = ~b8;
    lat = 0;
    busy_cnt = 0;
    while (get_done(wide) !== 1'b1 && lat < 40) begin
      if (get_busy(wide) === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check(wide ? "latency8" : "latency4", 64'(lat), 64'(w));
    check(wide ? "busy_cycles8" : "busy_cycles4", 64'(busy_cnt), 64'(w));
    @(negedge clk);
    check(wide ? "done_pulse8" : "done_pulse4", get_done(wide), 1'b0);
    check(wide ? "idle_busy8" : "idle_busy4", get_busy(wide), 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int done_cnt;
    int busy_seen;
    int t_first;
    int t_second;
    int unstable;

    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    check("rst_busy4", busy4, 1'b0);
    check("rst_done4", done4, 1'b0);
    check("rst_saida4", saida4, 0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_saida8", saida8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 10, 5);
    run_op(1'b0, 15, 15);
    run_op(1'b0, 0, 9);
    run_op(1'b0, 9, 10);

    // start held during CALC with changing operands must not disturb the result
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd8; b4 = 4'd6; q4.push_back(64'd48);
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd3;
    n = 0;
    while (done4 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      a4 = 4'($urandom); b4 = 4'($urandom);
    end
    start4 = 1'b0;
    check("ignored_start_latency", 64'(n), 64'd4);
    done_cnt = 0;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) done_cnt++;
      if (busy4 === 1'b1) busy_seen++;
    end
    check("no_second_done", 64'(done_cnt), 0);
    check("no_second_busy", 64'(busy_seen), 0);

    // start held high continuously: one accept every WIDTH+2 cycles
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
    q4.push_back(64'd49);
    q4.push_back(64'd49);
    n = 0; t_first = -1; t_second = -1; unstable = 0;
    while (t_second < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (t_first >= 0 && busy4 === 1'b1 && saida4 !== 8'd49) unstable++;
      if (done4 === 1'b1) begin
        if (t_first < 0) t_first = n;
        else t_second = n;
      end
    end
    start4 = 1'b0;
    check("held_start_period", 64'(t_second - t_first), 64'd6);
    check("held_saida_stable", 64'(unstable), 0);
    @(negedge clk);
    check("held_idle_busy", busy4, 1'b0);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd13; b4 = 4'd11; q4.push_back(64'd143);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    q4.delete();
    #1;
    check("abort_busy4", busy4, 1'b0);
    check("abort_done4", done4, 1'b0);
    check("abort_saida4", saida4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 13, 11);

    run_op(1'b1, 255, 255);
    run_op(1'b1, 128, 2);

    @(negedge clk);
    check("q4_drained", 64'(q4.size()), 0);
    check("q8_drained", 64'(q8.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
